calc_cmd_dispatcher: RTL



---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_cmd_fifo.sv | 66 ++++++
 rtl/calc_cmd_dispatcher.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculation-core command path: core-mode
// encodings, the NOP command mode, the dispatcher FSM states and the
// command-word width derivation.
package calc_pkg;

   // Encodings of the core's I_INPUTMODE input
   typedef enum logic [1:0] {
      MODE_IDLE        = 2'd0,
      INPUT_COORD_CORE = 2'd1,
      EXEC_CORE        = 2'd2,
      REF_RESULT       = 2'd3
   } core_mode_t;

   // Command mode field value that clears the core step counter
   localparam int MODE_NOP = 0;

   // Dispatcher FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Command word is {mode, opr1_addr, opr2_addr, ret_addr}
   function automatic int cmd_width(input int mode_w, input int addr_w);
      return mode_w + 3 * addr_w;
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO. Power-of-two depth, pointers wrap naturally.
// Head entry is visible on rdata whenever the FIFO is non-empty; the
// consumer captures it into its own register on pop. flush empties the
// FIFO and overrides a same-cycle push or pop.
module calc_cmd_fifo #(
   parameter int W     = 28,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level_reg == LVL_W'(DEPTH));
   assign empty   = (level_reg == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr_reg];
   assign level   = level_reg;

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop together leaves level unchanged
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/calc_cmd_dispatcher.sv
// Command dispatcher in front of the calculation core. Buffers commands,
// presents one at a time on top_cmd with core_mode=EXEC_CORE until the core
// reports finished_flag, then spends one NOP gap cycle so the core step
// counter returns to zero. Optional watchdog: define CALC_CMD_WATCHDOG_EN.
module calc_cmd_dispatcher
   import calc_pkg::*;
#(
   parameter int  MODE_W  = 4,
   parameter int  ADDR_W  = 8,
   parameter int  DEPTH   = 8,
   parameter int  TIMEOUT = 4095,
   localparam int CMD_W   = cmd_width(MODE_W, ADDR_W)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [CMD_W-1:0]       cmd_data,
   output logic [CMD_W-1:0]       top_cmd,
   output logic [1:0]             core_mode,
   input  logic                   finished_flag,
   output logic                   busy,
   output logic                   cmd_done,
   output logic [$clog2(DEPTH):0] level,
   output logic                   timeout_err
);

   // Command driven during the gap: NOP mode, all addresses zero
   localparam logic [CMD_W-1:0] NOP_CMD = {MODE_W'(MODE_NOP), (3 * ADDR_W)'(0)};

   state_t           state_reg;
   core_mode_t       core_mode_reg;
   logic [CMD_W-1:0] top_cmd_reg;
   logic             cmd_done_reg;
   logic             exec_first_reg;

   logic [CMD_W-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push_req;
   logic             pop_req;
   logic             finish_ok;
   logic             wd_expire;
   logic             wd_fire;

   // Completion is honoured only once the core has had a cycle to settle
   assign finish_ok = (state_reg == ST_EXEC) && !exec_first_reg && finished_flag;
   assign wd_fire   = wd_expire && !finish_ok;
   assign pop_req   = (state_reg == ST_IDLE) && !fifo_empty;
   assign push_req  = cmd_valid && cmd_ready;
   assign cmd_ready = !fifo_full && !timeout_err;

   calc_cmd_fifo #(
      .W     (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (wd_fire),
      .push  (push_req),
      .pop   (pop_req),
      .wdata (cmd_data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

`ifdef CALC_CMD_WATCHDOG_EN
   logic [15:0] wd_cnt_reg;
   logic        timeout_err_reg;

   // Expiry in the TIMEOUT-th EXEC cycle (counter starts at 0 on entry)
   assign wd_expire   = (state_reg == ST_EXEC) && (wd_cnt_reg == 16'(TIMEOUT - 1));
   assign timeout_err = timeout_err_reg;

   // Watchdog: count EXEC cycles, latch a sticky error when it fires
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (pop_req) begin
            wd_cnt_reg <= '0;
         end else if (state_reg == ST_EXEC) begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
         end
         if (wd_fire) begin
            timeout_err_reg <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;

   assign wd_expire      = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   // Dispatch FSM: IDLE -> EXEC (hold command) -> GAP (NOP) -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         core_mode_reg  <= MODE_IDLE;
         top_cmd_reg    <= '0;
         cmd_done_reg   <= 1'b0;
         exec_first_reg <= 1'b0;
      end else begin
         cmd_done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (pop_req) begin
                  state_reg      <= ST_EXEC;
                  top_cmd_reg    <= fifo_head;
                  core_mode_reg  <= EXEC_CORE;
                  exec_first_reg <= 1'b1;
               end
            end
            ST_EXEC: begin
               exec_first_reg <= 1'b0;
               if (finish_ok) begin
                  state_reg     <= ST_GAP;
                  top_cmd_reg   <= NOP_CMD;
                  core_mode_reg <= MODE_IDLE;
                  cmd_done_reg  <= 1'b1;
               end else if (wd_fire) begin
                  state_reg     <= ST_GAP;
                  top_cmd_reg   <= NOP_CMD;
                  core_mode_reg <= MODE_IDLE;
               end
            end
            ST_GAP: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg     <= ST_IDLE;
               top_cmd_reg   <= '0;
               core_mode_reg <= MODE_IDLE;
            end
         endcase
      end
   end

   assign top_cmd   = top_cmd_reg;
   assign core_mode = core_mode_reg;
   assign cmd_done  = cmd_done_reg;
   assign busy      = !fifo_empty || (state_reg != ST_IDLE);

endmodule
